// File: rtl/uart_wb_cmd_ctrl_if.sv
// Byte-stream and Wishbone signal bundle for the UART debug master.
// master: controller side; slave: UART cores plus Wishbone fabric side.
interface uart_wb_cmd_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [7:0]          rx_data;
  logic                rx_done;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                wb_cyc;
  logic                wb_stb;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_adr;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W/8-1:0] wb_sel;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack;
  logic                wb_err;
  logic                busy;
  logic                rx_drop;

  modport master (
    input  rx_data, rx_done, tx_ready,
    input  wb_dat_i, wb_ack, wb_err,
    output tx_data, tx_valid,
    output wb_cyc, wb_stb, wb_we,
    output wb_adr, wb_dat_o, wb_sel,
    output busy, rx_drop
  );

  modport slave (
    output rx_data, rx_done, tx_ready,
    output wb_dat_i, wb_ack, wb_err,
    input  tx_data, tx_valid,
    input  wb_cyc, wb_stb, wb_we,
    input  wb_adr, wb_dat_o, wb_sel,
    input  busy, rx_drop
  );
endinterface

// File: rtl/uart_wb_cmd_ctrl.sv
// UART command frame -> single Wishbone cycle -> status/read-data bytes.
// Ports: clk, rst (async, active-high), bus (uart_wb_cmd_ctrl_if.master).
module uart_wb_cmd_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  uart_wb_cmd_ctrl_if.master bus
);
  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int NB = (AB > DB) ? AB : DB;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  localparam logic [7:0] C_W = 8'h57;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] S_K = 8'h4B;
  localparam logic [7:0] S_E = 8'h45;

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, WB, RESP
  } state_t;

  state_t state, state_n;

  logic              we;
  logic              ok;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tmo;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        tx_data;

  logic rx_hdr;
  logic last_adr;
  logic last_dat;
  logic tmo_hit;
  logic wb_end;
  logic tx_acc;
  logic more;

  assign rx_hdr   = bus.rx_done &&
                    (bus.rx_data == C_W ||
                     bus.rx_data == C_R);
  assign last_adr = cnt == CW'(AB - 1);
  assign last_dat = cnt == CW'(DB - 1);
  assign tmo_hit  = tmo == TW'(TMO_CYC - 1);
  assign wb_end   = bus.wb_ack || bus.wb_err ||
                    tmo_hit;
  assign tx_acc   = (state == RESP) && bus.tx_ready;
  // read bytes still owed after the status byte
  assign more     = !we && ok && cnt != CW'(DB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (rx_hdr) state_n = RX_ADDR;
      RX_ADDR:
        if (bus.rx_done && last_adr)
          state_n = we ? RX_DATA : WB;
      RX_DATA:
        if (bus.rx_done && last_dat)
          state_n = WB;
      WB:
        if (wb_end) state_n = RESP;
      RESP:
        if (tx_acc && !more) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we      <= 1'b0;
      ok      <= 1'b0;
      cnt     <= '0;
      tmo     <= '0;
      adr     <= '0;
      dat_o   <= '0;
      rdata   <= '0;
      tx_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_hdr) begin
            we  <= bus.rx_data == C_W;
            cnt <= '0;
          end
        end
        RX_ADDR: begin
          if (bus.rx_done) begin
            adr <= ADDR_W'({adr, bus.rx_data});
            cnt <= last_adr ? '0 : cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bus.rx_done) begin
            dat_o <= DATA_W'({dat_o, bus.rx_data});
            cnt   <= last_dat ? '0 : cnt + 1'b1;
          end
        end
        WB: begin
          tmo <= tmo + 1'b1;
          if (wb_end) begin
            // ack wins over a simultaneous err
            cnt     <= '0;
            tmo     <= '0;
            ok      <= bus.wb_ack;
            tx_data <= bus.wb_ack ? S_K : S_E;
            if (bus.wb_ack && !we)
              rdata <= bus.wb_dat_i;
          end
        end
        RESP: begin
          if (tx_acc && more) begin
            tx_data <= rdata[DATA_W-1 -: 8];
            rdata   <= rdata << 8;
            cnt     <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wb_cyc   = state == WB;
  assign bus.wb_stb   = state == WB;
  assign bus.wb_we    = we;
  assign bus.wb_adr   = adr;
  assign bus.wb_dat_o = dat_o;
  assign bus.wb_sel   = {DB{state == WB}};
  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = state == RESP;
  assign bus.busy     = state != IDLE;
  assign bus.rx_drop  = bus.rx_done &&
                        (state == WB ||
                         state == RESP);
endmodule

// File: tb/tb_uart_wb_cmd_ctrl.sv
// Scoreboard bench for uart_wb_cmd_ctrl.
// Stimulus pushes expected WB cycles / TX bytes; monitors pop and compare.
module tb_uart_wb_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_wb_cmd_ctrl_if #(
    .ADDR_W(16), .DATA_W(32)
  ) bus ();

  uart_wb_cmd_ctrl #(
    .ADDR_W(16), .DATA_W(32), .TMO_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic        cd;
    int          len;
  } cyc_t;

  cyc_t       exp_cyc[$];
  logic [7:0] exp_tx[$];

  int tests = 0;
  int fails = 0;

  int          r_kind  = 0;
  int          r_delay = 0;
  logic [31:0] r_data  = '0;
  int          stall   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic do_frame(input logic we,
                          input logic [15:0] a,
                          input logic [31:0] d);
    send(we ? 8'h57 : 8'h52);
    send(a[15:8]);
    send(a[7:0]);
    if (we)
      for (int i = 3; i >= 0; i--)
        send(d[8*i +: 8]);
  endtask

  task automatic exp_wb(input logic we,
                        input logic [15:0] a,
                        input logic [31:0] d,
                        input logic cd,
                        input int len);
    cyc_t c;
    c.we = we; c.adr = a; c.dat = d;
    c.cd = cd; c.len = len;
    exp_cyc.push_back(c);
  endtask

  task automatic plan(input int k, input int dl,
                      input logic [31:0] d);
    r_kind = k; r_delay = dl; r_data = d;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (bus.busy) begin
      fails++;
      $display("FAIL %s: busy=1 after %0d clk want 0",
               nm, n);
    end
  endtask

  // Wishbone slave: ack/err on cycle index r_delay
  initial begin
    int cc = 0;
    bus.wb_ack = 1'b0;
    bus.wb_err = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.wb_cyc) begin
        if (r_kind != 0 && cc == r_delay) begin
          bus.wb_ack = r_kind == 1;
          bus.wb_err = r_kind == 2;
          bus.wb_dat_i = r_data;
        end else begin
          bus.wb_ack = 1'b0;
          bus.wb_err = 1'b0;
        end
        cc++;
      end else begin
        cc = 0;
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
      end
    end
  end

  // TX sink: ready after `stall` waiting cycles
  initial begin
    int wc = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!bus.tx_valid) begin
        bus.tx_ready = 1'b0; wc = 0;
      end else if (wc >= stall) begin
        bus.tx_ready = 1'b1; wc = 0;
      end else begin
        bus.tx_ready = 1'b0; wc++;
      end
    end
  end

  // TX monitor
  initial begin
    logic       pst = 1'b0;
    logic [7:0] pd  = '0;
    forever begin
      @(negedge clk);
      if (rst) pst = 1'b0;
      else begin
        if (pst) begin
          chk("tx_hold_valid", bus.tx_valid, 1);
          chk("tx_hold_data", bus.tx_data, pd);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_extra: got %0h want none",
                     bus.tx_data);
          end else
            chk("tx_byte", bus.tx_data,
                exp_tx.pop_front());
        end
        pst = bus.tx_valid && !bus.tx_ready;
        pd  = bus.tx_data;
      end
    end
  end

  // Wishbone monitor
  initial begin
    logic in_cyc = 1'b0;
    int   len = 0;
    cyc_t cur;
    cur.len = -1;
    forever begin
      @(negedge clk);
      if (rst) in_cyc = 1'b0;
      else if (bus.wb_cyc) begin
        chk("wb_stb", bus.wb_stb, 1);
        chk("wb_sel", bus.wb_sel, 4'hF);
        if (!in_cyc) begin
          in_cyc = 1'b1;
          len = 1;
          if (exp_cyc.size() == 0) begin
            tests++; fails++;
            cur.len = -1;
            $display("FAIL wb_extra: got adr %0h want none",
                     bus.wb_adr);
          end else begin
            cur = exp_cyc.pop_front();
            chk("wb_we", bus.wb_we, cur.we);
            chk("wb_adr", bus.wb_adr, cur.adr);
            if (cur.cd)
              chk("wb_dat_o", bus.wb_dat_o, cur.dat);
          end
        end else len++;
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        chk("wb_len", len, cur.len);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", bus.wb_cyc, 0);
    chk("rst_stb", bus.wb_stb, 0);
    chk("rst_we", bus.wb_we, 0);
    chk("rst_adr", bus.wb_adr, 0);
    chk("rst_dat_o", bus.wb_dat_o, 0);
    chk("rst_sel", bus.wb_sel, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: write, ack on third cycle
    plan(1, 2, 32'h0);
    exp_wb(1, 16'h1234, 32'hDEADBEEF, 1, 3);
    exp_tx.push_back(8'h4B);
    do_frame(1, 16'h1234, 32'hDEADBEEF);
    wait_idle("t1_idle");

    // 2: read
    plan(1, 1, 32'hCAFEF00D);
    exp_wb(0, 16'h0010, 32'h0, 0, 2);
    exp_tx.push_back(8'h4B);
    exp_tx.push_back(8'hCA);
    exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hF0);
    exp_tx.push_back(8'h0D);
    do_frame(0, 16'h0010, 32'h0);
    wait_idle("t2_idle");

    // 3: timeout
    plan(0, 0, 32'h0);
    exp_wb(0, 16'h0020, 32'h0, 0, 8);
    exp_tx.push_back(8'h45);
    do_frame(0, 16'h0020, 32'h0);
    wait_idle("t3_idle");
    chk("t3_tx_valid", bus.tx_valid, 0);

    // 4: noise byte, then err with a dropped rx
    bus.rx_data = 8'h41;
    bus.rx_done = 1'b1;
    @(negedge clk);
    chk("noise_no_drop", bus.rx_drop, 0);
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    chk("noise_idle", bus.busy, 0);
    plan(2, 3, 32'h0);
    exp_wb(1, 16'hABCD, 32'h01020304, 1, 4);
    exp_tx.push_back(8'h45);
    do_frame(1, 16'hABCD, 32'h01020304);
    @(posedge clk); #1;
    bus.rx_data = 8'h52;
    bus.rx_done = 1'b1;
    @(negedge clk);
    chk("wb_rx_drop", bus.rx_drop, 1);
    chk("wb_drop_cyc", bus.wb_cyc, 1);
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    @(negedge clk);
    chk("drop_no_pulse", bus.rx_drop, 0);
    chk("drop_still_cyc", bus.wb_cyc, 1);
    wait_idle("t4_idle");

    // 5: read with backpressure
    stall = 5;
    plan(1, 0, 32'h01234567);
    exp_wb(0, 16'h1200, 32'h0, 0, 1);
    exp_tx.push_back(8'h4B);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h23);
    exp_tx.push_back(8'h45);
    exp_tx.push_back(8'h67);
    do_frame(0, 16'h1200, 32'h0);
    wait_idle("t5_idle");
    chk("t5_q_empty", exp_tx.size(), 0);
    stall = 0;

    // 6a: reset mid-cycle
    plan(0, 0, 32'h0);
    exp_wb(0, 16'h0030, 32'h0, 0, 8);
    do_frame(0, 16'h0030, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rwb_cyc", bus.wb_cyc, 0);
    chk("rwb_stb", bus.wb_stb, 0);
    chk("rwb_tx_valid", bus.tx_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 6b: reset while status byte pending
    stall = 5;
    plan(1, 0, 32'h11223344);
    exp_wb(0, 16'h0040, 32'h0, 0, 1);
    do_frame(0, 16'h0040, 32'h0);
    n = 0;
    while (!bus.tx_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rresp_reached", bus.tx_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rresp_tx_valid", bus.tx_valid, 0);
    chk("rresp_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 0;

    // 6c: clean frame after reset
    plan(1, 0, 32'h0);
    exp_wb(1, 16'h0050, 32'hAABBCCDD, 1, 1);
    exp_tx.push_back(8'h4B);
    do_frame(1, 16'h0050, 32'hAABBCCDD);
    wait_idle("t6_idle");

    repeat (4) @(posedge clk);
    #1;
    chk("end_tx_q", exp_tx.size(), 0);
    chk("end_wb_q", exp_cyc.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
